id_stage: RTL
=============

# id_stage

Instruction-decode stage of the 5-stage word-addressed MIPS pipeline, directly downstream of instruction fetch. It holds the IF/ID latch and the register file, and decodes the instruction. Branches and jumps are resolved in ID, and RAW hazards are detected by stalling; there is no forwarding. Results go to EX through an internal ID/EX register.

## Interface
Parameters:
- none (widths fixed: 32-bit datapath, 5-bit register index, 4-bit ALU op)

Ports:
- clk  in  1  pipeline clock, all state on posedge
- rst  in  1  asynchronous, active-low reset
- if_pc4  in  32  PC+1 of instruction being fetched
- if_inst  in  32  instruction word from IF
- mem_we  in  1  instruction in MEM writes a register
- mem_rd  in  5  destination of instruction in MEM
- wb_we  in  1  register-file write enable from WB
- wb_rd  in  5  write address from WB
- wb_data  in  32  write data from WB
- id_wpcir  out  1  stall: hold PC and IF/ID (combinational)
- ctrl_branch  out  1  redirect PC to nid_pc (combinational)
- nid_pc  out  32  branch/jump target (combinational)
- jmp_stall  out  1  ID slot holds a squashed instruction (registered)
- ex_valid  out  1  ID/EX holds a real instruction
- ex_alu_op  out  4  ALU operation (INST_TYPE_* codes)
- ex_a, ex_b  out  32  rs data, rt data
- ex_imm  out  32  sign- or zero-extended immediate
- ex_shamt  out  5  shift amount
- ex_alu_src_imm  out  1  ALU B operand is ex_imm
- ex_we  out  1  writes register ex_rd
- ex_rd  out  5  destination (rd for R-type, rt for I-type)
- ex_mem_read, ex_mem_write  out  1  lw / sw
- ex_pc4  out  32  PC+1, for debug

## Operation
- IF/ID latch, on posedge:
  - id_wpcir=1: hold.
  - Else if ctrl_branch=1: load squash. The instruction becomes 0, the valid bit 0, and jmp_stall is set to 1.
  - Else: load if_inst and if_pc4, set valid to 1 and jmp_stall to 0.
- Decode uses OP_* and FUNC_* values:
  - Supported: ADD, SUB, AND, OR, NOR, SLT, SLL, SRL, SRA, ADDI, ANDI, ORI, LW, SW, BEQ, BNE, J.
  - Any other encoding decodes as a bubble (valid=0, no writes).
- Immediates: ADDI, LW, SW, BEQ and BNE use sign extension. ANDI and ORI use zero extension.
- Register-read usage:
  - R-type reads rs and rt; shifts read rt only.
  - ADDI, ANDI, ORI and LW read rs only.
  - SW, BEQ and BNE read rs and rt.
  - J reads nothing.
- Hazard: id_wpcir=1 when the ID instruction is valid and a used source register is nonzero and equals either:
  - ex_rd with ex_we=1 (ex_we is internal to this block), or
  - mem_rd with mem_we=1.
  - WB is covered by register-file write-through.
- Branch resolution (only when valid and id_wpcir=0):
  - BEQ: taken if a==b. BNE: taken if a!=b.
  - Taken branch: nid_pc = pc4 + sext(imm), and ctrl_branch=1.
  - J: nid_pc = {pc4[31:26], inst[25:0]}, and ctrl_branch=1.
  - Otherwise ctrl_branch=0 and nid_pc=0.
- ID/EX latch, on posedge:
  - id_wpcir=1 or invalid decode: load a bubble (all ex_* = 0).
  - Else: load the decoded fields.
  - BEQ, BNE and J pass to EX with ex_we=0 and no memory access.
- Register r0 always reads 0, and writes to it are ignored.

## Timing
- Reset (rst=0, asynchronous): all state and all registered outputs are 0. The IF/ID latch is invalid, jmp_stall=0, and the register file is cleared. The combinational outputs are therefore 0.
- Latency: an instruction is presented on if_inst in cycle N, sits in ID in cycle N+1, and appears on ex_* in cycle N+2.
- Load-use or ALU-use on the previous instruction: two stall cycles (the producer passes through EX, then MEM), then the read returns the WB data through write-through.
- Taken branch or jump: one squashed slot. jmp_stall=1 for exactly one cycle.
- Stall and branch in the same cycle: the stall wins. ctrl_branch=0 until the operands are clean.
- WB write and read of the same register in the same cycle: the read returns wb_data.
- Reset mid-stall: the stall is dropped immediately, and id_wpcir=0 while rst=0.

## Structure
- Shared constants go in macro.vh:
  - existing OP_* and FUNC_* opcodes,
  - INST_TYPE_* values reused as the 4-bit ALU op encoding,
  - a new NOP_INST constant (32'h0).
- Sub-module regfile: 32x32, two asynchronous read ports, one write port on posedge, r0 hardwired to 0, write-through bypass, asynchronous active-low clear.
- Hazard check, decode and branch compare stay in id_stage.

## Test plan
- Reset: hold rst=0 for 3 cycles with random if_inst. Required: all outputs 0 and id_wpcir=0. Release, then feed ADDI $1,$0,5. Required, two cycles later: ex_we=1, ex_rd=1, ex_imm=5, ex_alu_src_imm=1.
- Load-use: LW $2,0($0) followed by ADD $3,$2,$2. Required: id_wpcir=1 for exactly 2 cycles and 2 bubbles on ex_valid. Then, with WB writing $2=0x1234, ex_a=ex_b=0x1234.
- Taken BEQ: with $4=$5=7 and pc4=0x10, BEQ $4,$5,-3. Required: ctrl_branch=1, nid_pc=0x0D. Next cycle: jmp_stall=1 and ex_valid=0 for the squashed slot.
- Untaken BNE and J: BNE with equal operands gives ctrl_branch=0. J 0x25 with pc4=0x04000010 gives nid_pc=0x04000025.
- r0 and write-through: WB writes $0=0xFFFF, then read $0 gives 0. A simultaneous WB $6=0xAB and read $6 gives 0xAB.
- Illegal opcode 6'h3F: ex_valid=0, ex_we=0, ex_mem_write=0.

Source files
------------

// File: rtl/id_stage_pkg.sv
// Shared opcodes, ALU op encoding and the ID/EX payload for the decode stage.
package id_stage_pkg;
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FUNC_SLL = 6'h00;
   localparam logic [5:0] FUNC_SRL = 6'h02;
   localparam logic [5:0] FUNC_SRA = 6'h03;
   localparam logic [5:0] FUNC_ADD = 6'h20;
   localparam logic [5:0] FUNC_SUB = 6'h22;
   localparam logic [5:0] FUNC_AND = 6'h24;
   localparam logic [5:0] FUNC_OR  = 6'h25;
   localparam logic [5:0] FUNC_NOR = 6'h27;
   localparam logic [5:0] FUNC_SLT = 6'h2A;

   localparam logic [31:0] NOP_INST = 32'h0;

   typedef enum logic [3:0] {
      INST_TYPE_ADD = 4'd0,
      INST_TYPE_SUB = 4'd1,
      INST_TYPE_AND = 4'd2,
      INST_TYPE_OR  = 4'd3,
      INST_TYPE_NOR = 4'd4,
      INST_TYPE_SLT = 4'd5,
      INST_TYPE_SLL = 4'd6,
      INST_TYPE_SRL = 4'd7,
      INST_TYPE_SRA = 4'd8
   } alu_op_e;

   typedef struct packed {
      logic        valid;
      alu_op_e     alu_op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] imm;
      logic [4:0]  shamt;
      logic        alu_src_imm;
      logic        we;
      logic [4:0]  rd;
      logic        mem_read;
      logic        mem_write;
      logic [31:0] pc4;
   } ex_t;
endpackage

// File: rtl/id_stage_if.sv
// Bus between IF/MEM/WB, the decode stage and EX; slave is the decode side.
interface id_stage_if;
   logic [31:0] if_pc4;
   logic [31:0] if_inst;
   logic        mem_we;
   logic [4:0]  mem_rd;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        id_wpcir;
   logic        ctrl_branch;
   logic [31:0] nid_pc;
   logic        jmp_stall;
   logic        ex_valid;
   logic [3:0]  ex_alu_op;
   logic [31:0] ex_a;
   logic [31:0] ex_b;
   logic [31:0] ex_imm;
   logic [4:0]  ex_shamt;
   logic        ex_alu_src_imm;
   logic        ex_we;
   logic [4:0]  ex_rd;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic [31:0] ex_pc4;

   modport slave (
      input  if_pc4, if_inst, mem_we, mem_rd, wb_we, wb_rd, wb_data,
      output id_wpcir, ctrl_branch, nid_pc, jmp_stall, ex_valid, ex_alu_op,
             ex_a, ex_b, ex_imm, ex_shamt, ex_alu_src_imm, ex_we, ex_rd,
             ex_mem_read, ex_mem_write, ex_pc4
   );
   modport master (
      output if_pc4, if_inst, mem_we, mem_rd, wb_we, wb_rd, wb_data,
      input  id_wpcir, ctrl_branch, nid_pc, jmp_stall, ex_valid, ex_alu_op,
             ex_a, ex_b, ex_imm, ex_shamt, ex_alu_src_imm, ex_we, ex_rd,
             ex_mem_read, ex_mem_write, ex_pc4
   );
endinterface

// File: rtl/id_stage_regfile.sv
// 32x32 register file: two async read ports with write-through, r0 fixed at 0.
module id_stage_regfile
   import id_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  ra1_i,
   input  logic [4:0]  ra2_i,
   output logic [31:0] rd1_o,
   output logic [31:0] rd2_o,
   input  logic        we_i,
   input  logic [4:0]  wa_i,
   input  logic [31:0] wd_i
);
   logic [31:0] rf_q [32];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else if (we_i && wa_i != 5'd0) begin
         rf_q[wa_i] <= wd_i;
      end
   end

   // Same-cycle WB write is visible to the reader, so WB never needs a stall.
   always_comb begin
      rd1_o = rf_q[ra1_i];
      if (ra1_i == 5'd0)                  rd1_o = '0;
      else if (we_i && wa_i == ra1_i)     rd1_o = wd_i;
      rd2_o = rf_q[ra2_i];
      if (ra2_i == 5'd0)                  rd2_o = '0;
      else if (we_i && wa_i == ra2_i)     rd2_o = wd_i;
   end
endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID latch, register read, RAW stall, branch resolve, ID/EX latch.
module id_stage
   import id_stage_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   id_stage_if.slave bus
);
   logic [31:0] inst_q, pc4_q, ra, rb, imm_s, imm_z, imm;
   logic        valid_q, jstall_q;
   ex_t         ex_q, ex_d;
   logic [4:0]  rs, rt, rd, dst, shamt;
   logic        dec_ok, use_rs, use_rt, we, src_imm, mrd, mwr, is_beq, is_bne, is_j;
   logic        rs_hz, rt_hz, stall, take;
   alu_op_e     alu;

   assign rs    = inst_q[25:21];
   assign rt    = inst_q[20:16];
   assign rd    = inst_q[15:11];
   assign imm_s = {{16{inst_q[15]}}, inst_q[15:0]};
   assign imm_z = {16'h0, inst_q[15:0]};

   id_stage_regfile u_rf (
      .clk(clk), .rst_n(rst),
      .ra1_i(rs), .ra2_i(rt), .rd1_o(ra), .rd2_o(rb),
      .we_i(bus.wb_we), .wa_i(bus.wb_rd), .wd_i(bus.wb_data)
   );

   always_comb begin
      dec_ok = 1'b0; use_rs = 1'b0; use_rt = 1'b0; we = 1'b0; dst = '0;
      src_imm = 1'b0; mrd = 1'b0; mwr = 1'b0; imm = '0; shamt = '0;
      is_beq = 1'b0; is_bne = 1'b0; is_j = 1'b0; alu = INST_TYPE_ADD;
      case (inst_q[31:26])
         OP_RTYPE: begin
            dec_ok = 1'b1; use_rs = 1'b1; use_rt = 1'b1; we = 1'b1; dst = rd;
            case (inst_q[5:0])
               FUNC_ADD: alu = INST_TYPE_ADD;
               FUNC_SUB: alu = INST_TYPE_SUB;
               FUNC_AND: alu = INST_TYPE_AND;
               FUNC_OR:  alu = INST_TYPE_OR;
               FUNC_NOR: alu = INST_TYPE_NOR;
               FUNC_SLT: alu = INST_TYPE_SLT;
               FUNC_SLL: begin alu = INST_TYPE_SLL; use_rs = 1'b0; shamt = inst_q[10:6]; end
               FUNC_SRL: begin alu = INST_TYPE_SRL; use_rs = 1'b0; shamt = inst_q[10:6]; end
               FUNC_SRA: begin alu = INST_TYPE_SRA; use_rs = 1'b0; shamt = inst_q[10:6]; end
               default: begin
                  dec_ok = 1'b0; use_rs = 1'b0; use_rt = 1'b0; we = 1'b0; dst = '0;
               end
            endcase
         end
         OP_ADDI: begin dec_ok = 1'b1; use_rs = 1'b1; we = 1'b1; dst = rt; src_imm = 1'b1; imm = imm_s; end
         OP_ANDI: begin dec_ok = 1'b1; use_rs = 1'b1; we = 1'b1; dst = rt; src_imm = 1'b1; imm = imm_z; alu = INST_TYPE_AND; end
         OP_ORI:  begin dec_ok = 1'b1; use_rs = 1'b1; we = 1'b1; dst = rt; src_imm = 1'b1; imm = imm_z; alu = INST_TYPE_OR; end
         OP_LW:   begin dec_ok = 1'b1; use_rs = 1'b1; we = 1'b1; dst = rt; src_imm = 1'b1; imm = imm_s; mrd = 1'b1; end
         OP_SW:   begin dec_ok = 1'b1; use_rs = 1'b1; use_rt = 1'b1; src_imm = 1'b1; imm = imm_s; mwr = 1'b1; end
         OP_BEQ:  begin dec_ok = 1'b1; use_rs = 1'b1; use_rt = 1'b1; imm = imm_s; alu = INST_TYPE_SUB; is_beq = 1'b1; end
         OP_BNE:  begin dec_ok = 1'b1; use_rs = 1'b1; use_rt = 1'b1; imm = imm_s; alu = INST_TYPE_SUB; is_bne = 1'b1; end
         OP_J:    begin dec_ok = 1'b1; is_j = 1'b1; end
         default: ;
      endcase
   end

   // No forwarding: any in-flight producer in EX or MEM holds decode.
   assign rs_hz = use_rs && rs != 5'd0 &&
                  ((ex_q.we && ex_q.rd == rs) || (bus.mem_we && bus.mem_rd == rs));
   assign rt_hz = use_rt && rt != 5'd0 &&
                  ((ex_q.we && ex_q.rd == rt) || (bus.mem_we && bus.mem_rd == rt));
   assign stall = valid_q && (rs_hz || rt_hz);
   assign take  = valid_q && !stall &&
                  ((is_beq && ra == rb) || (is_bne && ra != rb) || is_j);

   assign bus.id_wpcir    = stall;
   assign bus.ctrl_branch = take;
   assign bus.nid_pc      = !take ? 32'h0 :
                            is_j  ? {pc4_q[31:26], inst_q[25:0]} : pc4_q + imm_s;
   assign bus.jmp_stall   = jstall_q;

   always_comb begin
      ex_d = '0;
      if (valid_q && dec_ok && !stall) begin
         ex_d.valid       = 1'b1;
         ex_d.alu_op      = alu;
         ex_d.a           = ra;
         ex_d.b           = rb;
         ex_d.imm         = imm;
         ex_d.shamt       = shamt;
         ex_d.alu_src_imm = src_imm;
         ex_d.we          = we;
         ex_d.rd          = dst;
         ex_d.mem_read    = mrd;
         ex_d.mem_write   = mwr;
         ex_d.pc4         = pc4_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inst_q   <= NOP_INST;
         pc4_q    <= '0;
         valid_q  <= 1'b0;
         jstall_q <= 1'b0;
         ex_q     <= '0;
      end else begin
         ex_q <= ex_d;
         if (!stall) begin
            if (take) begin
               inst_q   <= NOP_INST;
               valid_q  <= 1'b0;
               jstall_q <= 1'b1;
            end else begin
               inst_q   <= bus.if_inst;
               pc4_q    <= bus.if_pc4;
               valid_q  <= 1'b1;
               jstall_q <= 1'b0;
            end
         end
      end
   end

   assign bus.ex_valid       = ex_q.valid;
   assign bus.ex_alu_op      = ex_q.alu_op;
   assign bus.ex_a           = ex_q.a;
   assign bus.ex_b           = ex_q.b;
   assign bus.ex_imm         = ex_q.imm;
   assign bus.ex_shamt       = ex_q.shamt;
   assign bus.ex_alu_src_imm = ex_q.alu_src_imm;
   assign bus.ex_we          = ex_q.we;
   assign bus.ex_rd          = ex_q.rd;
   assign bus.ex_mem_read    = ex_q.mem_read;
   assign bus.ex_mem_write   = ex_q.mem_write;
   assign bus.ex_pc4         = ex_q.pc4;
endmodule
